pong_input_ctrl: RTL and testbench
==================================

Name: pong_input_ctrl

Overview:
- Front-end controller between the raw board inputs (BTN_UP, BTN_DOWN, SWITCHES) and the Pong game core.
- Synchronises and debounces the buttons, and latches the configuration switches only at frame boundaries.
- Once per video frame, issues one paddle command to the game core over a valid/ready handshake.
- Sits inside Pong, in the CLK_25MHZ domain, and is driven by a frame-start strobe from the VGA timing generator.

Parameters:
- DEBOUNCE_CYCLES, default 250000: consecutive stable cycles needed to accept a button change (10 ms at 25 MHz).
- CNT_W, default 18: width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- SPEED_STEP_FRAMES, default 8: held frames per speed increment.

Ports:
- CLK_25MHZ, in, 1: pixel clock; the only clock.
- RESET_N, in, 1: asynchronous, active-low reset.
- BTN_UP, in, 1: raw, asynchronous up button.
- BTN_DOWN, in, 1: raw, asynchronous down button.
- SWITCHES, in, 8: raw, asynchronous configuration switches.
- FRAME_START, in, 1: one-cycle pulse at the first blanking line of each frame.
- CMD_VALID, out, 1: a paddle command is pending.
- CMD_READY, in, 1: game core accepts the command.
- CMD_DIR, out, 2: 00 none, 01 up, 10 down; 11 is never driven.
- CMD_SPEED, out, 3: paddle step magnitude, 0..7.
- CFG, out, 8: frame-aligned switch value.
- OVERRUN, out, 1: one-cycle pulse when a pending command is superseded.

Behaviour:
- Reset (asynchronous, RESET_N=0): every flop clears. CMD_VALID=0, CMD_DIR=00, CMD_SPEED=0, CFG=0x00, OVERRUN=0, debounced button states=0, hold counter=0, FSM=IDLE. Release is recognised on the first clock edge with RESET_N=1.
- Synchronisers:
  - BTN_UP, BTN_DOWN and SWITCHES each pass through a 2-flop synchroniser.
  - Synchronised value is available 2 cycles after the input edge.
- Debounce (per button):
  - Counter clears whenever the synchronised value equals the debounced state.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced state toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Direction decode: up only -> 01; down only -> 10; both or neither -> 00.
- Hold counter (6-bit, saturating at 63):
  - Evaluated at FRAME_START only.
  - Same non-zero direction as the previous frame -> increments.
  - Otherwise -> clears to 0.
  - Speed = min(7, 1 + hold / SPEED_STEP_FRAMES) when direction is non-zero, else 0.
- CFG: loads the synchronised SWITCHES on the FRAME_START cycle only; holds between frames.
- Command FSM, 2 states:
  - IDLE: on FRAME_START, load CMD_DIR/CMD_SPEED from the current decode and go to PEND. CMD_VALID=1 from the next cycle (1-cycle latency).
  - PEND: CMD_VALID=1; payload stable while CMD_READY=0.
    - CMD_READY=1 -> IDLE. CMD_VALID=0 next cycle.
    - FRAME_START with CMD_READY=0 -> stay in PEND, reload payload with fresh values, pulse OVERRUN for one cycle.
    - FRAME_START and CMD_READY=1 in the same cycle -> the current payload is accepted, the new payload loads, and the FSM stays in PEND with CMD_VALID=1 and no OVERRUN.
- Direction 00 frames still issue a command (DIR=00, SPEED=0), so the core sees exactly one command per frame.
- CMD_READY while in IDLE is ignored.
- Reset asserted mid-PEND: the pending command is discarded and CMD_VALID drops immediately (asynchronous).

Decomposition:
- Shared package pong_pkg:
  - Direction encoding constants DIR_NONE, DIR_UP, DIR_DOWN.
  - FSM state typedef.
  - SPEED_MAX=7 and HOLD_MAX=63.
- Sub-module btn_debounce (one instance per button): 2-flop synchroniser plus counter plus debounced state. Parameters DEBOUNCE_CYCLES and CNT_W.
- The SWITCHES synchroniser stays inline.

Test Plan:
- Debounce, with DEBOUNCE_CYCLES=4, CNT_W=3:
  - Stimulus: BTN_UP high 3 cycles then low.
  - Required: no change; the next FRAME_START yields CMD_DIR=00, CMD_SPEED=0.
  - Stimulus: BTN_UP held 10 cycles.
  - Required: debounced up 2+4 cycles after the edge; next command CMD_DIR=01, CMD_SPEED=1.
- Speed ramp:
  - Stimulus: BTN_DOWN held for 20 frames, CMD_READY=1.
  - Required: CMD_DIR=10; CMD_SPEED 1 on frames 1-8, 2 on frames 9-16, 3 on frames 17-20.
  - Stimulus: release.
  - Required: next command 00/0.
- Both buttons:
  - Stimulus: BTN_UP=BTN_DOWN=1, stable.
  - Required: CMD_DIR=00, CMD_SPEED=0, hold counter cleared; a following up-only frame gives SPEED=1.
- Backpressure:
  - Stimulus: CMD_READY=0 across two FRAME_STARTs; direction up, then down.
  - Required: CMD_VALID stays 1; payload changes to 10 on the second strobe; OVERRUN=1 for exactly one cycle.
  - Stimulus: CMD_READY=1 on the same cycle as the next FRAME_START.
  - Required: no OVERRUN.
- CFG alignment:
  - Stimulus: SWITCHES change 0x00->0xA5 mid-frame.
  - Required: CFG stays 0x00 until the cycle after the next FRAME_START, then 0xA5.
- Async reset:
  - Stimulus: RESET_N=0 while in PEND with DIR=01.
  - Required: CMD_VALID=0, CFG=0x00 immediately, without a clock edge; after release, no command until the first FRAME_START.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared encodings and limits for the Pong input front-end.
package pong_pkg;
   localparam logic [1:0] DIR_NONE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   localparam int SPEED_MAX = 7;
   localparam int HOLD_MAX  = 63;

   typedef enum logic {IDLE, PEND} cmd_state_e;

   // Opposing buttons cancel out so the paddle never gets a contradictory command.
   function automatic logic [1:0] dir_decode(input logic up, input logic dn);
      if (up && !dn)      return DIR_UP;
      else if (dn && !up) return DIR_DOWN;
      else                return DIR_NONE;
   endfunction
endpackage

// File: rtl/pong_input_ctrl_if.sv
// Paddle command handshake between the input controller and the game core.
interface pong_input_ctrl_if;
   logic       CMD_VALID;
   logic       CMD_READY;
   logic [1:0] CMD_DIR;
   logic [2:0] CMD_SPEED;
   logic       OVERRUN;

   modport master (output CMD_VALID, CMD_DIR, CMD_SPEED, OVERRUN, input CMD_READY);
   modport slave  (input CMD_VALID, CMD_DIR, CMD_SPEED, OVERRUN, output CMD_READY);
endinterface

// File: rtl/pong_input_ctrl_btn_debounce.sv
// Two-flop synchroniser followed by a stable-time debouncer for one button.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic db_o
);
   logic             sync1_q, sync2_q;
   logic             db_q, db_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any sample matching the accepted state restarts the stability window.
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) db_d = ~db_q;
         else                                      cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign db_o = db_q;
endmodule

// File: rtl/pong_input_ctrl.sv
// Button/switch front-end: debounce, frame-aligned config, one paddle command per frame.
module pong_input_ctrl
   import pong_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 250000,
   parameter int CNT_W             = 18,
   parameter int SPEED_STEP_FRAMES = 8
) (
   input  logic              CLK_25MHZ,
   input  logic              RESET_N,
   input  logic              BTN_UP,
   input  logic              BTN_DOWN,
   input  logic [7:0]        SWITCHES,
   input  logic              FRAME_START,
   pong_input_ctrl_if.master cmd,
   output logic [7:0]        CFG
);
   logic       up_db, dn_db;
   logic [7:0] sw_s1_q, sw_s2_q, cfg_q;
   logic [1:0] dir_now, prev_dir_q;
   logic [5:0] hold_q, hold_d;
   logic [2:0] speed_now;
   int         ramp;

   cmd_state_e state_q, state_d;
   logic [1:0] dir_q, dir_d;
   logic [2:0] speed_q, speed_d;
   logic       ovr_q, ovr_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_up (
      .clk_i(CLK_25MHZ), .rst_ni(RESET_N), .btn_i(BTN_UP), .db_o(up_db));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_dn (
      .clk_i(CLK_25MHZ), .rst_ni(RESET_N), .btn_i(BTN_DOWN), .db_o(dn_db));

   assign dir_now = dir_decode(up_db, dn_db);

   // Speed is derived from the hold count as it stands after this frame's update.
   always_comb begin
      hold_d = '0;
      if (dir_now != DIR_NONE && dir_now == prev_dir_q)
         hold_d = (hold_q == 6'(HOLD_MAX)) ? hold_q : hold_q + 6'd1;
      ramp      = 1 + int'(hold_d) / SPEED_STEP_FRAMES;
      speed_now = '0;
      if (dir_now != DIR_NONE)
         speed_now = (ramp > SPEED_MAX) ? 3'(SPEED_MAX) : 3'(ramp);
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      speed_d = speed_q;
      ovr_d   = 1'b0;
      case (state_q)
         IDLE: if (FRAME_START) begin
            dir_d   = dir_now;
            speed_d = speed_now;
            state_d = PEND;
         end
         PEND: if (FRAME_START) begin
            dir_d   = dir_now;
            speed_d = speed_now;
            ovr_d   = !cmd.CMD_READY;
         end else if (cmd.CMD_READY) begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         cfg_q      <= '0;
         prev_dir_q <= DIR_NONE;
         hold_q     <= '0;
         state_q    <= IDLE;
         dir_q      <= DIR_NONE;
         speed_q    <= '0;
         ovr_q      <= 1'b0;
      end else begin
         sw_s1_q <= SWITCHES;
         sw_s2_q <= sw_s1_q;
         if (FRAME_START) begin
            cfg_q      <= sw_s2_q;
            prev_dir_q <= dir_now;
            hold_q     <= hold_d;
         end
         state_q <= state_d;
         dir_q   <= dir_d;
         speed_q <= speed_d;
         ovr_q   <= ovr_d;
      end
   end

   assign cmd.CMD_VALID = (state_q == PEND);
   assign cmd.CMD_DIR   = dir_q;
   assign cmd.CMD_SPEED = speed_q;
   assign cmd.OVERRUN   = ovr_q;
   assign CFG           = cfg_q;
endmodule

// File: tb/tb_pong_input_ctrl.sv
// Self-checking bench for pong_input_ctrl with a frame-level reference model.
module tb_pong_input_ctrl;
   import pong_pkg::*;

   logic       clk = 1'b0, rst_n = 1'b0, up = 1'b0, dn = 1'b0, fs = 1'b0;
   logic [7:0] sw = 8'h00;
   logic [7:0] cfg;
   int passed = 0, total = 0;
   int m_prev = 0, m_hold = 0;
   int edir, espd;

   pong_input_ctrl_if cmd_if();

   always #20 clk = ~clk;

   pong_input_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .SPEED_STEP_FRAMES(8)) dut (
      .CLK_25MHZ(clk), .RESET_N(rst_n), .BTN_UP(up), .BTN_DOWN(dn),
      .SWITCHES(sw), .FRAME_START(fs), .cmd(cmd_if), .CFG(cfg));

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) tick();
   endtask

   function automatic int model_dir(input logic u, input logic d);
      if (u && !d) return 1;
      if (d && !u) return 2;
      return 0;
   endfunction

   // Buttons are assumed stable well beyond the debounce window before each frame.
   task automatic do_frame(output int d, output int s);
      fs = 1'b1; tick(); fs = 1'b0;
      d = model_dir(up, dn);
      if (d != 0 && d == m_prev) m_hold = (m_hold < 63) ? m_hold + 1 : 63;
      else                       m_hold = 0;
      m_prev = d;
      s = (d == 0) ? 0 : (((1 + m_hold / 8) > 7) ? 7 : 1 + m_hold / 8);
   endtask

   task automatic test_reset();
      cmd_if.CMD_READY = 1'b1;
      wait_cyc(3);
      total++; if (cmd_if.CMD_VALID !== 1'b0) $display("FAIL rst_valid got %b want 0", cmd_if.CMD_VALID); else passed++;
      total++; if (cmd_if.CMD_DIR !== 2'b00) $display("FAIL rst_dir got %b want 00", cmd_if.CMD_DIR); else passed++;
      total++; if (cmd_if.CMD_SPEED !== 3'd0) $display("FAIL rst_speed got %0d want 0", cmd_if.CMD_SPEED); else passed++;
      total++; if (cfg !== 8'h00) $display("FAIL rst_cfg got %h want 00", cfg); else passed++;
      total++; if (cmd_if.OVERRUN !== 1'b0) $display("FAIL rst_ovr got %b want 0", cmd_if.OVERRUN); else passed++;
      rst_n = 1'b1;
      wait_cyc(4);
      total++; if (cmd_if.CMD_VALID !== 1'b0) $display("FAIL idle_no_cmd got %b want 0", cmd_if.CMD_VALID); else passed++;
   endtask

   task automatic test_debounce();
      up = 1'b1; wait_cyc(3); up = 1'b0;
      wait_cyc(10);
      total++; if (dut.u_up.db_o !== 1'b0) $display("FAIL glitch_db got %b want 0", dut.u_up.db_o); else passed++;
      do_frame(edir, espd);
      total++; if (cmd_if.CMD_VALID !== 1'b1) $display("FAIL glitch_valid got %b want 1", cmd_if.CMD_VALID); else passed++;
      total++; if (cmd_if.CMD_DIR !== 2'(edir) || edir != 0) $display("FAIL glitch_dir got %b want 00", cmd_if.CMD_DIR); else passed++;
      total++; if (cmd_if.CMD_SPEED !== 3'd0) $display("FAIL glitch_speed got %0d want 0", cmd_if.CMD_SPEED); else passed++;
      tick();
      total++; if (cmd_if.CMD_VALID !== 1'b0) $display("FAIL accept_drop got %b want 0", cmd_if.CMD_VALID); else passed++;
      up = 1'b1; wait_cyc(5);
      total++; if (dut.u_up.db_o !== 1'b0) $display("FAIL db_early got %b want 0", dut.u_up.db_o); else passed++;
      tick();
      total++; if (dut.u_up.db_o !== 1'b1) $display("FAIL db_on_time got %b want 1", dut.u_up.db_o); else passed++;
      wait_cyc(4);
      do_frame(edir, espd);
      total++; if (cmd_if.CMD_DIR !== 2'b01) $display("FAIL up_dir got %b want 01", cmd_if.CMD_DIR); else passed++;
      total++; if (cmd_if.CMD_SPEED !== 3'd1) $display("FAIL up_speed got %0d want 1", cmd_if.CMD_SPEED); else passed++;
      tick();
   endtask

   task automatic test_speed_ramp();
      int want;
      up = 1'b0; dn = 1'b1; wait_cyc(10);
      for (int f = 1; f <= 20; f++) begin
         do_frame(edir, espd);
         want = (f <= 8) ? 1 : ((f <= 16) ? 2 : 3);
         total++; if (cmd_if.CMD_DIR !== 2'b10) $display("FAIL ramp_dir f%0d got %b want 10", f, cmd_if.CMD_DIR); else passed++;
         total++; if (cmd_if.CMD_SPEED !== 3'(want) || espd != want) $display("FAIL ramp_speed f%0d got %0d want %0d", f, cmd_if.CMD_SPEED, want); else passed++;
         wait_cyc(4);
      end
      dn = 1'b0; wait_cyc(10);
      do_frame(edir, espd);
      total++; if (cmd_if.CMD_DIR !== 2'b00 || cmd_if.CMD_SPEED !== 3'd0) $display("FAIL release got %b/%0d want 00/0", cmd_if.CMD_DIR, cmd_if.CMD_SPEED); else passed++;
      tick();
   endtask

   task automatic test_both();
      up = 1'b1; dn = 1'b1; wait_cyc(10);
      do_frame(edir, espd);
      total++; if (cmd_if.CMD_DIR !== 2'b00 || cmd_if.CMD_SPEED !== 3'd0) $display("FAIL both got %b/%0d want 00/0", cmd_if.CMD_DIR, cmd_if.CMD_SPEED); else passed++;
      total++; if (dut.hold_q !== 6'd0) $display("FAIL both_hold got %0d want 0", dut.hold_q); else passed++;
      tick();
      dn = 1'b0; wait_cyc(10);
      do_frame(edir, espd);
      total++; if (cmd_if.CMD_DIR !== 2'b01 || cmd_if.CMD_SPEED !== 3'd1) $display("FAIL after_both got %b/%0d want 01/1", cmd_if.CMD_DIR, cmd_if.CMD_SPEED); else passed++;
      tick();
   endtask

   task automatic test_backpressure();
      int changed = 0, ovr_cnt = 0;
      cmd_if.CMD_READY = 1'b0;
      up = 1'b1; dn = 1'b0; wait_cyc(10);
      do_frame(edir, espd);
      total++; if (cmd_if.CMD_VALID !== 1'b1 || cmd_if.CMD_DIR !== 2'b01) $display("FAIL bp_first got %b/%b want 1/01", cmd_if.CMD_VALID, cmd_if.CMD_DIR); else passed++;
      up = 1'b0; dn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (cmd_if.CMD_VALID !== 1'b1 || cmd_if.CMD_DIR !== 2'b01 || cmd_if.OVERRUN !== 1'b0) changed++;
      end
      total++; if (changed != 0) $display("FAIL bp_stable got %0d changes want 0", changed); else passed++;
      do_frame(edir, espd);
      total++; if (cmd_if.CMD_DIR !== 2'b10 || cmd_if.CMD_SPEED !== 3'(espd)) $display("FAIL bp_reload got %b/%0d want 10/%0d", cmd_if.CMD_DIR, cmd_if.CMD_SPEED, espd); else passed++;
      for (int i = 0; i < 5; i++) begin
         if (cmd_if.OVERRUN === 1'b1) ovr_cnt++;
         total++; if (cmd_if.CMD_VALID !== 1'b1) $display("FAIL bp_valid c%0d got %b want 1", i, cmd_if.CMD_VALID); else passed++;
         tick();
      end
      total++; if (ovr_cnt != 1) $display("FAIL bp_ovr_pulses got %0d want 1", ovr_cnt); else passed++;
      cmd_if.CMD_READY = 1'b1;
      do_frame(edir, espd);
      total++; if (cmd_if.OVERRUN !== 1'b0) $display("FAIL same_cycle_ovr got %b want 0", cmd_if.OVERRUN); else passed++;
      total++; if (cmd_if.CMD_VALID !== 1'b1 || cmd_if.CMD_DIR !== 2'b10 || cmd_if.CMD_SPEED !== 3'(espd)) $display("FAIL same_cycle_cmd got %b/%b/%0d want 1/10/%0d", cmd_if.CMD_VALID, cmd_if.CMD_DIR, cmd_if.CMD_SPEED, espd); else passed++;
      tick();
      total++; if (cmd_if.CMD_VALID !== 1'b0) $display("FAIL bp_drain got %b want 0", cmd_if.CMD_VALID); else passed++;
   endtask

   task automatic test_cfg();
      total++; if (cfg !== 8'h00) $display("FAIL cfg_pre got %h want 00", cfg); else passed++;
      sw = 8'hA5; wait_cyc(5);
      total++; if (cfg !== 8'h00) $display("FAIL cfg_mid got %h want 00", cfg); else passed++;
      do_frame(edir, espd);
      total++; if (cfg !== 8'hA5) $display("FAIL cfg_load got %h want a5", cfg); else passed++;
      tick();
   endtask

   task automatic test_random();
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(2) == 0) begin up = 1'($urandom); dn = 1'($urandom); end
         sw = 8'($urandom);
         wait_cyc(10);
         do_frame(edir, espd);
         total++; if (cmd_if.CMD_VALID !== 1'b1 || cmd_if.CMD_DIR !== 2'(edir) || cmd_if.CMD_SPEED !== 3'(espd))
            $display("FAIL rnd_cmd f%0d got %b/%b/%0d want 1/%0d/%0d", f, cmd_if.CMD_VALID, cmd_if.CMD_DIR, cmd_if.CMD_SPEED, edir, espd);
         else passed++;
         total++; if (cfg !== sw) $display("FAIL rnd_cfg f%0d got %h want %h", f, cfg, sw); else passed++;
         tick();
      end
   endtask

   task automatic test_async_reset();
      int spurious = 0;
      cmd_if.CMD_READY = 1'b0;
      up = 1'b1; dn = 1'b0; wait_cyc(10);
      do_frame(edir, espd);
      total++; if (cmd_if.CMD_VALID !== 1'b1 || cmd_if.CMD_DIR !== 2'b01) $display("FAIL ar_pend got %b/%b want 1/01", cmd_if.CMD_VALID, cmd_if.CMD_DIR); else passed++;
      #5 rst_n = 1'b0;
      #1;
      total++; if (cmd_if.CMD_VALID !== 1'b0) $display("FAIL ar_valid got %b want 0", cmd_if.CMD_VALID); else passed++;
      total++; if (cfg !== 8'h00) $display("FAIL ar_cfg got %h want 00", cfg); else passed++;
      m_prev = 0; m_hold = 0;
      wait_cyc(2);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (cmd_if.CMD_VALID !== 1'b0) spurious++;
      end
      total++; if (spurious != 0) $display("FAIL ar_quiet got %0d valid cycles want 0", spurious); else passed++;
      do_frame(edir, espd);
      total++; if (cmd_if.CMD_VALID !== 1'b1 || cmd_if.CMD_DIR !== 2'b01 || cmd_if.CMD_SPEED !== 3'd1) $display("FAIL ar_first got %b/%b/%0d want 1/01/1", cmd_if.CMD_VALID, cmd_if.CMD_DIR, cmd_if.CMD_SPEED); else passed++;
      cmd_if.CMD_READY = 1'b1;
      tick();
   endtask

   initial begin
      cmd_if.CMD_READY = 1'b1;
      test_reset();
      test_debounce();
      test_speed_ramp();
      test_both();
      test_backpressure();
      test_cfg();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
